// File: rtl/branch_predictor.sv
// Per-PC 2-bit saturating-counter branch history table with combinational
// prediction, resolve-time mispredict flag and branch/mispredict statistics.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic [3:0]           upd_branch,
  input  logic                 upd_taken,
  output logic                 upd_mispredict,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            bht [ENTRIES];
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  upd_event;
  logic [1:0]            upd_ctr;
  logic [1:0]            upd_next;

  // Tag bits, word offset and condition code do not affect the table.
  logic unused_bits;
  assign unused_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                         upd_pc[31:INDEX_BITS+2], upd_pc[1:0], upd_branch[2:0]};

  assign pred_idx   = pred_pc[INDEX_BITS+1:2];
  assign upd_idx    = upd_pc[INDEX_BITS+1:2];
  assign pred_taken = bht[pred_idx][1];

  // Saturating counter step and mispredict against the pre-update counter.
  always_comb begin
    upd_event      = upd_valid & upd_branch[3];
    upd_ctr        = bht[upd_idx];
    upd_next       = upd_ctr;
    upd_mispredict = 1'b0;
    if (upd_taken && (upd_ctr != 2'b11)) begin
      upd_next = upd_ctr + 2'd1;
    end else if (!upd_taken && (upd_ctr != 2'b00)) begin
      upd_next = upd_ctr - 2'd1;
    end
    if (upd_event) begin
      upd_mispredict = (upd_ctr[1] != upd_taken);
    end
  end

  // Reset wins over a coincident update; all entries return to weak-NT.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        bht[INDEX_BITS'(i)] <= 2'b01;
      end
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (upd_event) begin
      bht[upd_idx] <= upd_next;
      branch_cnt   <= branch_cnt + CNT_WIDTH'(1);
      if (upd_mispredict) begin
        mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected values,
// a negedge monitor pops and compares against the DUT outputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_branch;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  logic        rst4;
  logic [31:0] pred_pc4;
  logic        pred_taken4;
  logic        upd4_valid;
  logic [31:0] upd4_pc;
  logic [3:0]  upd4_branch;
  logic        upd4_taken;
  logic        upd_mispredict4;
  logic [3:0]  branch_cnt4;
  logic [3:0]  mispredict_cnt4;

  branch_predictor u_dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_branch(upd_branch),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .pred_pc(pred_pc4), .pred_taken(pred_taken4),
    .upd_valid(upd4_valid), .upd_pc(upd4_pc), .upd_branch(upd4_branch),
    .upd_taken(upd4_taken), .upd_mispredict(upd_mispredict4),
    .branch_cnt(branch_cnt4), .mispredict_cnt(mispredict_cnt4)
  );

  typedef struct {
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  function automatic logic [31:0] actual_of(input int sig);
    case (sig)
      0:       return {31'd0, pred_taken};
      1:       return {31'd0, upd_mispredict};
      2:       return branch_cnt;
      3:       return mispredict_cnt;
      4:       return {28'd0, branch_cnt4};
      5:       return {28'd0, mispredict_cnt4};
      6:       return {31'd0, upd_mispredict4};
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: every expectation queued during a cycle is checked mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = actual_of(e.sig);
      total_cnt++;
      if (act === e.val) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.val, $time);
    end
  end

  task automatic expect_val(input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [3:0] br, input logic tk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_branch = br;
    upd_taken  = tk;
  endtask

  task automatic idle();
    upd_valid  = 1'b0;
    upd_pc     = 32'd0;
    upd_branch = 4'd0;
    upd_taken  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checked %0d", total_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic tp[4];
    logic np[3];
    tp = '{1'b0, 1'b1, 1'b1, 1'b1};
    np = '{1'b1, 1'b1, 1'b0};

    rst = 1'b1; pred_pc = 32'd0; idle();
    rst4 = 1'b1; pred_pc4 = 32'd0;
    upd4_valid = 1'b0; upd4_pc = 32'd0; upd4_branch = 4'd0; upd4_taken = 1'b0;
    cyc(); cyc();
    rst = 1'b0; rst4 = 1'b0;

    // Reset sweep across all indices
    for (int i = 0; i < 64; i++) begin
      pred_pc = 32'(i * 4);
      expect_val(0, 32'd0, "reset_sweep_pred");
      if (i == 0) begin
        expect_val(1, 32'd0, "reset_misp");
        expect_val(2, 32'd0, "reset_branch_cnt");
        expect_val(3, 32'd0, "reset_misp_cnt");
      end
      cyc();
    end

    // Taken then not-taken training at 0x40
    pred_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      upd(32'h40, 4'b1000, 1'b1);
      expect_val(0, {31'd0, tp[i]}, "taken_pred");
      expect_val(1, (i == 0) ? 32'd1 : 32'd0, "taken_misp");
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      upd(32'h40, 4'b1000, 1'b0);
      expect_val(0, {31'd0, np[i]}, "nt_pred");
      expect_val(1, {31'd0, np[i]}, "nt_misp");
      cyc();
    end
    idle();
    expect_val(0, 32'd0, "nt_final_pred");
    expect_val(2, 32'd7, "train_branch_cnt");
    expect_val(3, 32'd3, "train_misp_cnt");
    cyc();

    // Non-branch instructions leave everything alone
    pred_pc = 32'h80;
    for (int i = 0; i < 10; i++) begin
      upd(32'h80, 4'b0000, 1'b1);
      expect_val(0, 32'd0, "nonbr_pred");
      expect_val(1, 32'd0, "nonbr_misp");
      cyc();
    end
    idle();
    expect_val(0, 32'd0, "nonbr_after_pred");
    expect_val(2, 32'd7, "nonbr_branch_cnt");
    expect_val(3, 32'd3, "nonbr_misp_cnt");
    cyc();

    // Aliasing: 0x004 and 0x104 share index 1
    pred_pc = 32'h004;
    upd(32'h004, 4'b1001, 1'b1);
    expect_val(0, 32'd0, "alias_pred0");
    expect_val(1, 32'd1, "alias_misp0");
    cyc();
    upd(32'h104, 4'b1101, 1'b1);
    expect_val(0, 32'd1, "alias_pred1");
    expect_val(1, 32'd0, "alias_misp1");
    cyc();
    idle();
    expect_val(0, 32'd1, "alias_pred_004");
    cyc();
    pred_pc = 32'h104;
    expect_val(0, 32'd1, "alias_pred_104");
    expect_val(2, 32'd9, "alias_branch_cnt");
    expect_val(3, 32'd4, "alias_misp_cnt");
    cyc();

    // Same-cycle predict/update: no bypass
    pred_pc = 32'h20;
    upd(32'h20, 4'b1000, 1'b1);
    expect_val(0, 32'd0, "samecyc_pred_old");
    expect_val(1, 32'd1, "samecyc_misp");
    cyc();
    idle();
    expect_val(0, 32'd1, "samecyc_pred_new");
    expect_val(1, 32'd0, "idle_misp");
    expect_val(2, 32'd10, "samecyc_branch_cnt");
    expect_val(3, 32'd5, "samecyc_misp_cnt");
    cyc();

    // Unused condition code still counts
    pred_pc = 32'h30;
    upd(32'h30, 4'b1010, 1'b1);
    expect_val(0, 32'd0, "cc010_pred");
    expect_val(1, 32'd1, "cc010_misp");
    cyc();
    idle();
    expect_val(0, 32'd1, "cc010_pred_after");
    expect_val(2, 32'd11, "cc010_branch_cnt");
    expect_val(3, 32'd6, "cc010_misp_cnt");
    cyc();

    // Reset coincident with updates, held for three edges
    rst = 1'b1;
    upd(32'h40, 4'b1000, 1'b1);
    cyc();
    expect_val(2, 32'd0, "rsthold_branch_cnt");
    expect_val(3, 32'd0, "rsthold_misp_cnt");
    cyc();
    cyc();
    rst = 1'b0;
    idle();
    pred_pc = 32'h004;
    expect_val(0, 32'd0, "rst_pred_004");
    expect_val(2, 32'd0, "rst_branch_cnt");
    expect_val(3, 32'd0, "rst_misp_cnt");
    cyc();
    pred_pc = 32'h20;
    expect_val(0, 32'd0, "rst_pred_020");
    cyc();
    pred_pc = 32'h30;
    expect_val(0, 32'd0, "rst_pred_030");
    cyc();
    pred_pc = 32'h40;
    upd(32'h40, 4'b1000, 1'b1);
    expect_val(0, 32'd0, "rst_pred_040");
    expect_val(1, 32'd1, "rst_wnt_misp_040");
    cyc();
    upd(32'h004, 4'b1000, 1'b0);
    expect_val(0, 32'd1, "rst_wnt_pred_040");
    expect_val(1, 32'd0, "rst_wnt_misp_004");
    cyc();
    idle();
    pred_pc = 32'h004;
    expect_val(0, 32'd0, "rst_post_pred_004");
    expect_val(2, 32'd2, "rst_post_branch_cnt");
    expect_val(3, 32'd1, "rst_post_misp_cnt");
    cyc();

    // Narrow counters: alternating directions mispredict every time, both wrap
    for (int i = 0; i < 16; i++) begin
      upd4_valid  = 1'b1;
      upd4_pc     = 32'h0;
      upd4_branch = 4'b1000;
      upd4_taken  = (i % 2 == 0);
      expect_val(6, 32'd1, "wrap_misp");
      if (i > 0) begin
        expect_val(4, 32'(i), "wrap_branch_cnt");
        expect_val(5, 32'(i), "wrap_misp_cnt");
      end
      cyc();
    end
    upd4_valid = 1'b0;
    expect_val(4, 32'd0, "wrapped_branch_cnt");
    expect_val(5, 32'd0, "wrapped_misp_cnt");
    cyc();

    cyc();
    total_cnt++;
    if (sb.size() == 0) pass_cnt++;
    else $display("FAIL sb_drain: %0d left, expected 0", sb.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
